// File: rtl/timer_pkg.sv
// Shared definitions for the down-count interval timer: FSM state encoding
// and default data widths.
package timer_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_PWIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/downcount_prescaler.sv
// Prescale down counter: emits a tick on every enabled cycle where it sits at
// zero, then reloads to the captured prescale value.
module downcount_prescaler
  import timer_pkg::*;
#(
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic [PWIDTH-1:0] i_load_val,
  input  logic              i_en,
  input  logic [PWIDTH-1:0] i_reload_val,
  output logic              o_tick
);

  logic [PWIDTH-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      if (r_cnt == '0) begin
        r_cnt <= i_reload_val;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/downcount_timer_ctrl.sv
// Programmable interval timer controller: captures config on start, counts
// down once per prescaled tick, and flags terminal count (one-shot or periodic).
module downcount_timer_ctrl
  import timer_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PWIDTH = DEF_PWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cfg_load,
  input  logic [PWIDTH-1:0] cfg_prescale,
  input  logic              cfg_reload,
  input  logic              start,
  input  logic              hold,
  input  logic              halt,
  output logic [WIDTH-1:0]  count,
  output logic              busy,
  output logic              done,
  output logic              tc_pulse
);

  state_t            r_state;
  logic [WIDTH-1:0]  r_count;
  logic [WIDTH-1:0]  r_reload_val;
  logic [PWIDTH-1:0] r_presc_val;
  logic              r_mode;
  logic              r_busy;
  logic              r_done;
  logic              r_tc_pulse;

  state_t            w_next_state;
  logic [WIDTH-1:0]  w_next_count;
  logic              w_next_tc;
  logic              w_capture;
  logic              w_presc_en;
  logic              w_tick;

  downcount_prescaler #(
    .PWIDTH(PWIDTH)
  ) u_prescaler (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_capture),
    .i_load_val   (cfg_prescale),
    .i_en         (w_presc_en),
    .i_reload_val (r_presc_val),
    .o_tick       (w_tick)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_next_tc    = 1'b0;
    w_capture    = 1'b0;
    w_presc_en   = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_capture = 1'b1;
        end
      end
      RUN: begin
        w_presc_en = !hold;
        if (w_tick) begin
          if (r_count != '0) begin
            w_next_count = r_count - 1'b1;
          end else begin
            w_next_tc = 1'b1;
            if (r_mode) begin
              w_next_count = r_reload_val;
            end else begin
              w_next_state = DONE;
            end
          end
        end
      end
      default: w_next_state = IDLE;
    endcase

    if (w_capture) begin
      w_next_state = RUN;
      w_next_count = cfg_load;
    end

    // Halt beats everything, including a start and a terminal tick.
    if (halt) begin
      w_next_state = IDLE;
      w_next_count = '0;
      w_next_tc    = 1'b0;
      w_capture    = 1'b0;
      w_presc_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_count      <= '0;
      r_reload_val <= '0;
      r_presc_val  <= '0;
      r_mode       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tc_pulse   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_count    <= w_next_count;
      r_busy     <= (w_next_state == RUN);
      r_done     <= (w_next_state == DONE);
      r_tc_pulse <= w_next_tc;
      if (w_capture) begin
        r_reload_val <= cfg_load;
        r_presc_val  <= cfg_prescale;
        r_mode       <= cfg_reload;
      end
    end
  end

  assign count    = r_count;
  assign busy     = r_busy;
  assign done     = r_done;
  assign tc_pulse = r_tc_pulse;

endmodule

// File: doc/downcount_timer_ctrl.md
Name: downcount_timer_ctrl

Overview:
- Controller that sequences an 8-bit down counter as a programmable interval timer.
- Captures a load value and prescale value on start, then decrements the count once per prescaled tick.
- Flags terminal count and then either stops (one-shot) or reloads (periodic).
- Sits between software-visible configuration inputs and downstream logic that consumes the count value and the terminal-count pulse.

Parameters:
- WIDTH, 8, width of count, load value and reload register.
- PWIDTH, 8, width of prescale value and prescale counter.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_load  input  WIDTH  count start/reload value; sampled only when start is accepted.
- cfg_prescale  input  PWIDTH  tick divider; tick period is cfg_prescale+1 clocks; sampled only when start is accepted.
- cfg_reload  input  1  1 = periodic (auto-reload), 0 = one-shot; sampled only when start is accepted.
- start  input  1  level-sampled request to begin timing.
- hold  input  1  freezes the prescaler and count while in RUN.
- halt  input  1  aborts timing and returns to IDLE.
- count  output  WIDTH  current counter value.
- busy  output  1  high in RUN.
- done  output  1  high in DONE (one-shot expired).
- tc_pulse  output  1  one-cycle terminal-count strobe.

Behaviour:
- Reset: rst is synchronous and active-high; clock port is clk. Reset has priority over all other inputs.
- Reset values: state=IDLE, count=0, prescale counter=0, reload_val=0, presc_val=0, mode=0, busy=0, done=0, tc_pulse=0.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE, start=1 and halt=0:
  - capture reload_val<=cfg_load, presc_val<=cfg_prescale, mode<=cfg_reload;
  - set count<=cfg_load, prescale counter<=cfg_prescale;
  - next state RUN. Latency: start in cycle N gives count=cfg_load and busy=1 in cycle N+1.
- RUN, hold=0:
  - If prescale counter==0, a tick occurs and the prescale counter reloads to presc_val. Otherwise the prescale counter decrements by 1.
  - On a tick with count!=0: count<=count-1.
  - On a tick with count==0 (terminal): tc_pulse<=1 for exactly the next cycle.
    - mode=1: count<=reload_val; stay in RUN.
    - mode=0: count stays 0; state<=DONE.
- RUN, hold=1: prescale counter and count frozen; no tick; tc_pulse=0.
- Period: (load+1)*(prescale+1) clocks between tc_pulses. A load of 0 gives a tc every prescale+1 clocks.
- DONE:
  - done=1, count=0.
  - start=1 restarts exactly as from IDLE (fresh config capture).
  - halt=1 goes to IDLE.
- halt=1 in any state: next state IDLE, count<=0, tc_pulse<=0.
- Priority: halt over start. Halt takes effect even on a terminal tick, and that tc is suppressed.
- Ignored inputs:
  - start while in RUN.
  - cfg_* changes while in RUN or DONE (only the values captured at start are used).
  - hold outside RUN.
- Arithmetic: unsigned, modulo 2^WIDTH. count never decrements below 0. The only wrap path is via reload.
- tc_pulse is never high for two consecutive cycles unless load=0 and prescale=0 in periodic mode, where it is continuously high.

Decomposition:
- Shared package (timer_pkg): state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default WIDTH/PWIDTH.
- Sub-module downcount_prescaler: PWIDTH down counter with load/enable inputs and a tick output. It is instantiated once.
- FSM, count register and reload register stay in downcount_timer_ctrl.

Test Plan:
- Reset: rst=1 for 2 cycles mid-RUN -> next cycle count=0, busy=0, done=0, tc_pulse=0, state IDLE.
- One-shot: cfg_load=3, cfg_prescale=0, cfg_reload=0, start at cycle 0 -> count 3,2,1,0 on cycles 1-4; tc_pulse=1 and done=1 at cycle 5; busy=0 from cycle 5.
- Periodic with prescale: cfg_load=2, cfg_prescale=1, cfg_reload=1 -> tc_pulse every 6 cycles, count sequence 2,2,1,1,0,0 repeating, busy stays 1.
- Hold: one-shot load=5, prescale=0; hold=1 for 4 cycles when count=3 -> count stays 3 for 4 cycles, then resumes; tc arrives 4 cycles later than without hold.
- Halt vs start: assert halt and start together on the terminal-tick cycle -> no tc_pulse, state IDLE, count=0. Then start alone -> RUN with newly sampled cfg_load.
- Config isolation: change cfg_load from 4 to 9 during RUN (periodic, load=4) -> reload still 4. Load=0 periodic with prescale=0 -> tc_pulse continuously 1.
